mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle HI/LO multiply/divide unit. Sits downstream of the register file:
//  consumes RData1/RData2 as SrcA/SrcB on MULT/MULTU/DIV/DIVU/MTHI/MTLO.
//  Holds HI/LO, which feed MFHI/MFLO write-back. Asserts Busy so control stalls
//  the issue of further HI/LO instructions.
// PARAMETERS
//  MULT_CYCLES  5   cycles from accepted mult Start to HI/LO update (>=1)
//  DIV_CYCLES   10  cycles from accepted div Start to HI/LO update (>=1)
// PORTS
//  Clk       in   1   clock, all state updates on posedge
//  ResetReg  in   1   reset, synchronous, active-low (0 = reset)
//  Start     in   1   issue strobe, sampled each posedge
//  Op        in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//  SrcA      in   32  rs operand (dividend / multiplicand / MTHI,MTLO data)
//  SrcB      in   32  rt operand (divisor / multiplier)
//  Busy      out  1   operation in flight
//  HI        out  32  HI register
//  LO        out  32  LO register
// BEHAVIOUR
//  - Reset (ResetReg==0 at posedge): HI=0, LO=0, Busy=0, counter=0, pending op
//    discarded. Reset mid-operation aborts it; no HI/LO update follows.
//  - Accept rule: Start && !Busy. Start while Busy is ignored entirely (no queueing).
//  - States: IDLE, RUN. IDLE->RUN on accepted op 0-3: latch Op/SrcA/SrcB, load
//    counter with MULT_CYCLES or DIV_CYCLES, Busy=1 from the next cycle.
//    RUN: decrement each cycle; at count==1 the edge writes HI/LO and returns to
//    IDLE. Busy==0 in the cycle after the update. Net latency N = HI/LO visible
//    N cycles after the accepting edge.
//  - MTHI/MTLO (op 4/5) when accepted: write SrcA to HI/LO at the same edge, no
//    Busy. Ignored while Busy. Ops 6-7: no effect.
//  - MULT: {HI,LO} = signed 64-bit product. MULTU: unsigned 64-bit product.
//  - DIV: LO = quotient truncated toward zero; HI = remainder, sign of dividend.
//    -2^31 / -1: LO=0x80000000, HI=0x00000000. DIVU: unsigned.
//  - Divisor 0 (DIV/DIVU): full latency and Busy still apply, HI/LO unchanged.
//  - Operands are taken from the latched copy; SrcA/SrcB may change after accept.
//  - HI/LO change only at: reset, result commit, MTHI/MTLO. Outputs are registered.
// STRUCTURE
//  - Shared package/header: Op encodings (MD_MULT..MD_MTLO), state encodings.
//  - One sub-module: md_counter (loadable down-counter, done pulse at count==1).
//  - Arithmetic may be combinational on the latched operands, committed at done.
// TESTING
//  1 Reset: ResetReg=0 for 2 cycles mid-DIV -> HI=LO=0, Busy=0, no later commit.
//  2 MULT A=0xFFFFFFFE(-2), B=3 -> after 5 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA;
//    MULTU same operands -> HI=0x00000002, LO=0xFFFFFFFA.
//  3 DIV A=-7, B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7/2 ->
//    LO=3, HI=1; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
//  4 DIV by 0 with HI=0x11, LO=0x22 -> Busy 10 cycles, HI/LO unchanged.
//  5 Start MULT then Start MTHI 0xABCD while Busy -> MTHI ignored, product lands.
//  6 MTLO 0x1234 while idle -> LO=0x1234 next edge, Busy stays 0; Busy exactly
//    high for MULT_CYCLES cycles on back-to-back accepted mults.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings and datapath arithmetic for the HI/LO multiply/divide unit.
// Latency: n/a (package). Backpressure: n/a.
package mult_div_unit_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NOP6  = 3'd6,
        MD_NOP7  = 3'd7
    } md_op_e;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    function automatic logic md_is_arith(input md_op_e op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // Returns {HI, LO}. Signed ops work on magnitudes and fix signs afterwards so
    // -2^31 / -1 wraps to 0x80000000 without any special case.
    function automatic logic [63:0] md_result(input md_op_e op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic        sgn;
        logic        neg_a;
        logic        neg_b;
        logic [31:0] ua;
        logic [31:0] ub;
        logic [31:0] uq;
        logic [31:0] ur;
        logic [63:0] res;
        sgn   = (op == MD_MULT) || (op == MD_DIV);
        neg_a = sgn & a[31];
        neg_b = sgn & b[31];
        ua    = neg_a ? (32'd0 - a) : a;
        ub    = neg_b ? (32'd0 - b) : b;
        if (ub == 32'd0) begin
            ub = 32'd1;
        end
        uq  = ua / ub;
        ur  = ua % ub;
        res = 64'd0;
        case (op)
            MD_MULT, MD_MULTU: res = {{32{neg_a}}, a} * {{32{neg_b}}, b};
            MD_DIV, MD_DIVU:   res = {(neg_a ? (32'd0 - ur) : ur),
                                      ((neg_a ^ neg_b) ? (32'd0 - uq) : uq)};
            default:           res = 64'd0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mult_div_unit_counter.sv
// Loadable down-counter; done is high while the count equals one.
// Latency: load visible next cycle. Backpressure: none, load always wins.
module md_counter #(
    parameter int W = 4
) (
    input  logic         Clk,
    input  logic         ResetReg,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count_q;

    always_ff @(posedge Clk) begin
        if (!ResetReg) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (count_q != '0) begin
            count_q <= count_q - W'(1);
        end
    end

    assign done = (count_q == W'(1));

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit with MTHI/MTLO moves.
// Latency: MULT_CYCLES / DIV_CYCLES from accept to HI/LO; moves take one edge.
// Backpressure: Busy high while running; any Start during Busy is dropped.
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        ResetReg,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    md_state_e   state_q;
    md_op_e      op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;

    md_op_e      op_in;
    logic        accept;
    logic        launch;
    logic [CW-1:0] load_val;
    logic        cnt_done;
    logic        commit;
    logic        div_zero;
    logic [63:0] result;

    always_comb begin
        op_in    = md_op_e'(Op);
        accept   = Start && (state_q == MD_IDLE);
        launch   = accept && md_is_arith(op_in);
        load_val = md_is_div(op_in) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        commit   = (state_q == MD_RUN) && cnt_done;
        div_zero = md_is_div(op_q) && (b_q == 32'd0);
        result   = md_result(op_q, a_q, b_q);
    end

    md_counter #(.W(CW)) u_counter (
        .Clk      (Clk),
        .ResetReg (ResetReg),
        .load     (launch),
        .load_val (load_val),
        .done     (cnt_done)
    );

    always_ff @(posedge Clk) begin
        if (!ResetReg) begin
            state_q <= MD_IDLE;
            busy_q  <= 1'b0;
            op_q    <= MD_MULT;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (accept) begin
                        case (op_in)
                            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                                op_q    <= op_in;
                                a_q     <= SrcA;
                                b_q     <= SrcB;
                                state_q <= MD_RUN;
                                busy_q  <= 1'b1;
                            end
                            MD_MTHI: hi_q <= SrcA;
                            MD_MTLO: lo_q <= SrcA;
                            default: ;
                        endcase
                    end
                end
                MD_RUN: begin
                    if (commit) begin
                        state_q <= MD_IDLE;
                        busy_q  <= 1'b0;
                        // Divide by zero burns the full latency but leaves HI/LO alone.
                        if (!div_zero) begin
                            hi_q <= result[63:32];
                            lo_q <= result[31:0];
                        end
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

    assign Busy = busy_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit with hand-computed vectors.
module tb_mult_div_unit;

    logic        Clk;
    logic        ResetReg;
    logic        Start;
    logic [2:0]  Op;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk      (Clk),
        .ResetReg (ResetReg),
        .Start    (Start),
        .Op       (Op),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .Busy     (Busy),
        .HI       (HI),
        .LO       (LO)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue an op for one cycle, scramble operands, then count Busy cycles while
    // checking HI/LO hold their old values until the commit edge.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int exp_len, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        logic [31:0] hi0;
        logic [31:0] lo0;
        int          len;
        hi0   = HI;
        lo0   = LO;
        Start = 1'b1;
        Op    = op;
        SrcA  = a;
        SrcB  = b;
        tick();
        Start = 1'b0;
        SrcA  = ~a;
        SrcB  = ~b;
        len   = 0;
        for (int i = 0; i < 64 && Busy; i++) begin
            chk({tag, "_hold_hi"}, HI, hi0);
            chk({tag, "_hold_lo"}, LO, lo0);
            len++;
            tick();
        end
        chk({tag, "_busy_len"}, 32'(len), 32'(exp_len));
        chk({tag, "_hi"}, HI, exp_hi);
        chk({tag, "_lo"}, LO, exp_lo);
    endtask

    task automatic move(input logic [2:0] op, input logic [31:0] a);
        Start = 1'b1;
        Op    = op;
        SrcA  = a;
        SrcB  = 32'h0;
        tick();
        Start = 1'b0;
    endtask

    initial begin
        ResetReg = 1'b0;
        Start    = 1'b0;
        Op       = 3'd0;
        SrcA     = 32'h0;
        SrcB     = 32'h0;
        tick();
        tick();
        ResetReg = 1'b1;
        chk("rst_busy", {31'd0, Busy}, 32'd0);
        chk("rst_hi", HI, 32'h0);
        chk("rst_lo", LO, 32'h0);

        // MTLO while idle: visible after one edge, never busy.
        move(3'd5, 32'h0000_1234);
        chk("mtlo_lo", LO, 32'h0000_1234);
        chk("mtlo_hi", HI, 32'h0);
        chk("mtlo_busy", {31'd0, Busy}, 32'd0);

        run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("b2b_mult", 3'd0, 32'd6, 32'd7, 5, 32'h0, 32'd42);

        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

        move(3'd4, 32'h0000_0011);
        move(3'd5, 32'h0000_0022);
        chk("mthi_hi", HI, 32'h0000_0011);
        run_op("div0", 3'd2, 32'd5, 32'd0, 10, 32'h0000_0011, 32'h0000_0022);
        run_op("divu0", 3'd3, 32'hFFFF_FFFF, 32'd0, 10, 32'h0000_0011, 32'h0000_0022);

        // Ops 6 and 7 leave everything untouched.
        move(3'd6, 32'hDEAD_BEEF);
        move(3'd7, 32'hDEAD_BEEF);
        chk("nop_busy", {31'd0, Busy}, 32'd0);
        chk("nop_hi", HI, 32'h0000_0011);
        chk("nop_lo", LO, 32'h0000_0022);

        // MTHI issued while a MULT is in flight is dropped.
        Start = 1'b1; Op = 3'd0; SrcA = 32'd100; SrcB = 32'hFFFF_FFFF;
        tick();
        Op = 3'd4; SrcA = 32'h0000_ABCD;
        tick();
        Start = 1'b0;
        chk("mthi_busy_hi", HI, 32'h0000_0011);
        chk("mthi_busy_flag", {31'd0, Busy}, 32'd1);
        for (int i = 0; i < 64 && Busy; i++) tick();
        chk("mthi_busy_done", {31'd0, Busy}, 32'd0);
        chk("mthi_busy_prod_hi", HI, 32'hFFFF_FFFF);
        chk("mthi_busy_prod_lo", LO, 32'hFFFF_FF9C);
        tick();
        chk("mthi_busy_late_hi", HI, 32'hFFFF_FFFF);

        // Reset in the middle of a DIV aborts it with no late commit.
        Start = 1'b1; Op = 3'd2; SrcA = 32'd100; SrcB = 32'd7;
        tick();
        Start = 1'b0;
        tick();
        tick();
        ResetReg = 1'b0;
        tick();
        tick();
        ResetReg = 1'b1;
        chk("rstmid_busy", {31'd0, Busy}, 32'd0);
        chk("rstmid_hi", HI, 32'h0);
        chk("rstmid_lo", LO, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        chk("rstmid_late_busy", {31'd0, Busy}, 32'd0);
        chk("rstmid_late_hi", HI, 32'h0);
        chk("rstmid_late_lo", LO, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
